// File: rtl/tsc_leak_decoder.sv
// tsc_leak_decoder: receive side of the key-leakage channel.
// Each 64-bit sample carries one modulated bit per byte lane. The lane value
// is majority-voted, descrambled against a replica 20-bit LFSR, and counted as
// a +1/-1 vote per key bit over WINDOW accepted samples. The recovered key byte
// is then offered on a valid/ready handshake.
// Optional build macro TSC_DEC_LANE_ERR_EN enables the non-unanimous-sample
// counter on lane_err_cnt; without it the output is tied to zero.
module tsc_leak_decoder #(
  parameter int WINDOW = 256,
  parameter int ACC_W  = $clog2(WINDOW) + 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         arm,
  input  logic [127:0] data,
  input  logic [63:0]  load_in,
  input  logic         load_vld,
  output logic [7:0]   key_est,
  output logic         key_vld,
  input  logic         key_rdy,
  output logic         busy,
  output logic [15:0]  lane_err_cnt
);

  localparam int CNT_W = $clog2(WINDOW);
  localparam logic signed [ACC_W-1:0] VOTE_UP = ACC_W'(1);
  localparam logic signed [ACC_W-1:0] VOTE_DN = ACC_W'(-1);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

  state_t                   state_q, state_d;
  logic [19:0]              lfsr_q, lfsr_d;
  logic signed [ACC_W-1:0]  acc_q [8];
  logic signed [ACC_W-1:0]  acc_d [8];
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [7:0]               key_q, key_d;
  logic [7:0]               demod;
  logic                     take, last;

  // Only the seed bits of the plaintext matter here.
  logic unused_data;
  assign unused_data = ^data[127:20];

  // Majority vote of one byte lane: five or more ones reads as a 1.
  function automatic logic lane_bit(input logic [7:0] lane);
    logic [3:0] ones;
    ones = '0;
    for (int j = 0; j < 8; j++) ones = ones + {3'b000, lane[j]};
    return ones >= 4'd5;
  endfunction

  function automatic logic [19:0] lfsr_step(input logic [19:0] s);
    return {s[18:0], s[19] ^ s[16]};
  endfunction

  // An all-zero LFSR would lock up, so a zero seed is forced to 1.
  function automatic logic [19:0] seed_fix(input logic [19:0] s);
    return (s == 20'h0) ? 20'h00001 : s;
  endfunction

  // Arm always wins over a coincident sample or handshake.
  assign take = (state_q == S_ACCUM) && load_vld && !arm;
  assign last = take && (cnt_q == CNT_W'(WINDOW - 1));

  // Descramble each lane with the LFSR state from before this sample's step.
  always_comb begin
    demod = '0;
    for (int i = 0; i < 8; i++) demod[i] = lane_bit(load_in[8*i +: 8]) ^ lfsr_q[i];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (arm) begin
      state_d = S_ACCUM;
    end else begin
      case (state_q)
        S_ACCUM: if (last)    state_d = S_DONE;
        S_DONE:  if (key_rdy) state_d = S_IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  // Status outputs decoded from the registered state only.
  always_comb begin
    busy    = (state_q == S_ACCUM);
    key_vld = (state_q == S_DONE);
  end

  // Datapath next values: reseed on arm, vote and step on each accepted sample.
  always_comb begin
    lfsr_d = lfsr_q;
    cnt_d  = cnt_q;
    key_d  = key_q;
    for (int i = 0; i < 8; i++) acc_d[i] = acc_q[i];
    if (arm) begin
      lfsr_d = seed_fix(data[19:0]);
      cnt_d  = '0;
      for (int i = 0; i < 8; i++) acc_d[i] = '0;
    end else if (take) begin
      lfsr_d = lfsr_step(lfsr_q);
      cnt_d  = cnt_q + CNT_W'(1);
      for (int i = 0; i < 8; i++) acc_d[i] = acc_q[i] + (demod[i] ? VOTE_UP : VOTE_DN);
      if (last) begin
        // A tied vote resolves to 0.
        for (int i = 0; i < 8; i++) key_d[i] = (acc_d[i] > 0);
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= 20'h00001;
      cnt_q  <= '0;
      key_q  <= '0;
      for (int i = 0; i < 8; i++) acc_q[i] <= '0;
    end else begin
      lfsr_q <= lfsr_d;
      cnt_q  <= cnt_d;
      key_q  <= key_d;
      for (int i = 0; i < 8; i++) acc_q[i] <= acc_d[i];
    end
  end

  assign key_est = key_q;

`ifdef TSC_DEC_LANE_ERR_EN
  logic [15:0] err_q;
  logic        mixed;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // A sample is suspect when any lane is not a clean 00/FF.
  always_comb begin
    mixed = 1'b0;
    for (int i = 0; i < 8; i++)
      if ((load_in[8*i +: 8] != 8'h00) && (load_in[8*i +: 8] != 8'hFF)) mixed = 1'b1;
  end

  // Saturating count of suspect samples within the current estimate.
  always_ff @(posedge clk) begin
    if (rst || arm)           err_q <= '0;
    else if (take && mixed)   err_q <= sat_inc16(err_q);
  end

  assign lane_err_cnt = err_q;
`else
  assign lane_err_cnt = 16'h0000;
`endif

endmodule
